// File: rtl/data_mem_arbiter.sv
// Two-master arbiter/sequencer for the single-port data memory: one transaction at a
// time, one-cycle memory request, fixed read latency, one-cycle ready to the granted master.
module data_mem_arbiter #(
   parameter bit          RR_EN       = 1'b1,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wd_i,
   output logic [31:0] m0_rd_o,
   output logic        m0_ready_o,
   output logic        m0_stall_o,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wd_i,
   output logic [31:0] m1_rd_o,
   output logic        m1_ready_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // The counter holds the number of WAIT cycles still to go, so it is loaded with
   // MEM_LATENCY-1; that makes RESP land exactly MEM_LATENCY cycles after the issue.
   localparam logic [2:0] WAIT_CYCLES = 3'(MEM_LATENCY - 1);

   logic [1:0] state_q, state_d;
   logic       grant_q, grant_d;
   logic       last_grant_q, last_grant_d;
   logic [2:0] cnt_q, cnt_d;

   logic any_req;
   logic winner;
   logic issue;
   logic resp;

   always_comb begin
      any_req = m0_req_i | m1_req_i;
      if (m0_req_i && m1_req_i) begin
         winner = RR_EN ? ~last_grant_q : 1'b0;
      end else begin
         winner = ~m0_req_i;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               grant_d = winner;
               if (MEM_LATENCY <= 1) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_CYCLES;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

   // Issue is combinational from IDLE; reset gates it so the bus is quiet while held.
   always_comb begin
      issue      = (state_q == S_IDLE) && any_req && !rst_i;
      resp       = (state_q == S_RESP);
      mem_req_o  = issue;
      mem_we_o   = issue & (winner ? m1_we_i : m0_we_i);
      mem_addr_o = issue ? (winner ? m1_addr_i : m0_addr_i) : '0;
      mem_wd_o   = issue ? (winner ? m1_wd_i : m0_wd_i) : '0;
      m0_ready_o = resp & ~grant_q;
      m1_ready_o = resp & grant_q;
      m0_rd_o    = m0_ready_o ? mem_rd_i : '0;
      m1_rd_o    = m1_ready_o ? mem_rd_i : '0;
      m0_stall_o = m0_req_i & ~m0_ready_o;
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: three configurations share stimulus, each with
// its own latency-accurate memory model; checks are hand-computed per cycle.
module tb_data_mem_arbiter;

   localparam bit          RRS  [3] = '{1'b1, 1'b0, 1'b1};
   localparam int unsigned LATS [3] = '{1, 1, 3};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wd = '0, m1_addr = '0, m1_wd = '0;

   logic [31:0] m0_rd [3];
   logic [31:0] m1_rd [3];
   logic [31:0] mem_addr [3];
   logic [31:0] mem_wd [3];
   logic [31:0] mem_rd [3];
   logic        m0_ready [3];
   logic        m0_stall [3];
   logic        m1_ready [3];
   logic        mem_req [3];
   logic        mem_we [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] dflt(input logic [3:0] a);
      case (a)
         4'd4:    return 32'hDEAD_BEEF;
         4'd9:    return 32'hCAFE_0009;
         default: return {28'hC0DE_000, a};
      endcase
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gi
      data_mem_arbiter #(.RR_EN(RRS[g]), .MEM_LATENCY(LATS[g])) dut (
         .clk_i(clk), .rst_i(rst),
         .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wd_i(m0_wd),
         .m0_rd_o(m0_rd[g]), .m0_ready_o(m0_ready[g]), .m0_stall_o(m0_stall[g]),
         .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wd_i(m1_wd),
         .m1_rd_o(m1_rd[g]), .m1_ready_o(m1_ready[g]),
         .mem_req_o(mem_req[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
         .mem_wd_o(mem_wd[g]), .mem_rd_i(mem_rd[g])
      );

      // Memory data is valid only in the cycle exactly LATS[g] after the request.
      logic [31:0] mem [16];
      logic [15:0] written = '0;
      logic [3:0]  raddr = '0;
      logic [2:0]  vcnt = '0;
      always @(posedge clk or posedge rst) begin
         if (rst) begin
            vcnt <= '0;
         end else if (mem_req[g]) begin
            if (mem_we[g]) begin
               mem[mem_addr[g][5:2]]     <= mem_wd[g];
               written[mem_addr[g][5:2]] <= 1'b1;
            end
            raddr <= mem_addr[g][5:2];
            vcnt  <= 3'(LATS[g]);
         end else if (vcnt != 3'd0) begin
            vcnt <= vcnt - 3'd1;
         end
      end
      assign mem_rd[g] = (vcnt == 3'd1) ? (written[raddr] ? mem[raddr] : dflt(raddr))
                                        : 32'h0BAD_0BAD;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      next_cycle();
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            check_val($sformatf("rst_mem_req[%0d]", i), 32'(mem_req[i]), 32'd0);
            check_val($sformatf("rst_mem_we[%0d]", i), 32'(mem_we[i]), 32'd0);
            check_val($sformatf("rst_mem_addr[%0d]", i), mem_addr[i], 32'd0);
            check_val($sformatf("rst_mem_wd[%0d]", i), mem_wd[i], 32'd0);
            check_val($sformatf("rst_rdy[%0d]", i), 32'({m0_ready[i], m1_ready[i]}), 32'd0);
            check_val($sformatf("rst_rd[%0d]", i), m0_rd[i] | m1_rd[i], 32'd0);
            check_val($sformatf("rst_stall[%0d]", i), 32'(m0_stall[i]), 32'(m0_req));
         end
      end
      next_cycle();
      rst = 1'b0;
   endtask

   initial begin
      // m0 single read, latency 1 (instance 0)
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_wd = 32'hFFFF_0000;
      do_reset();
      @(negedge clk);
      check_val("A_req_N", 32'(mem_req[0]), 32'd1);
      check_val("A_addr_N", mem_addr[0], 32'h10);
      check_val("A_we_N", 32'(mem_we[0]), 32'd0);
      check_val("A_stall_N", 32'(m0_stall[0]), 32'd1);
      check_val("A_rdy_N", 32'(m0_ready[0]), 32'd0);
      next_cycle();
      @(negedge clk);
      check_val("A_rdy_N1", 32'(m0_ready[0]), 32'd1);
      check_val("A_rd_N1", m0_rd[0], 32'hDEAD_BEEF);
      check_val("A_stall_N1", 32'(m0_stall[0]), 32'd0);
      check_val("A_req_N1", 32'(mem_req[0]), 32'd0);
      check_val("A_m1rdy_N1", 32'(m1_ready[0]), 32'd0);
      check_val("A_m1rd_N1", m1_rd[0], 32'd0);
      next_cycle();
      m0_req = 1'b0;

      // Both masters requesting: RR (inst 0) alternates, fixed (inst 1) keeps m0
      m0_req = 1'b1; m0_addr = 32'h10; m1_req = 1'b1; m1_addr = 32'h24; m1_we = 1'b0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c > 0) next_cycle();
         if (c == 8) m0_req = 1'b0;
         @(negedge clk);
         if (c < 8) begin
            check_val($sformatf("B_rr_req_c%0d", c), 32'(mem_req[0]), 32'(c % 2 == 0));
            check_val($sformatf("B_rr_addr_c%0d", c), mem_addr[0],
                      (c % 2 == 1) ? 32'h0 : ((c % 4 == 0) ? 32'h10 : 32'h24));
            check_val($sformatf("B_rr_m0rdy_c%0d", c), 32'(m0_ready[0]), 32'(c % 4 == 1));
            check_val($sformatf("B_rr_m1rdy_c%0d", c), 32'(m1_ready[0]), 32'(c % 4 == 3));
            check_val($sformatf("B_rr_m0rd_c%0d", c), m0_rd[0],
                      (c % 4 == 1) ? 32'hDEAD_BEEF : 32'h0);
            check_val($sformatf("B_rr_m1rd_c%0d", c), m1_rd[0],
                      (c % 4 == 3) ? 32'hCAFE_0009 : 32'h0);
            check_val($sformatf("B_rr_stall_c%0d", c), 32'(m0_stall[0]), 32'(c % 4 != 1));
            check_val($sformatf("B_fp_req_c%0d", c), 32'(mem_req[1]), 32'(c % 2 == 0));
            check_val($sformatf("B_fp_addr_c%0d", c), mem_addr[1],
                      (c % 2 == 0) ? 32'h10 : 32'h0);
            check_val($sformatf("B_fp_m0rdy_c%0d", c), 32'(m0_ready[1]), 32'(c % 2 == 1));
            check_val($sformatf("B_fp_m1rdy_c%0d", c), 32'(m1_ready[1]), 32'd0);
         end else begin
            for (int i = 0; i < 2; i++) begin
               check_val($sformatf("B_tail_req_c%0d[%0d]", c, i), 32'(mem_req[i]), 32'(c == 8));
               check_val($sformatf("B_tail_addr_c%0d[%0d]", c, i), mem_addr[i],
                         (c == 8) ? 32'h24 : 32'h0);
               check_val($sformatf("B_tail_m0rdy_c%0d[%0d]", c, i), 32'(m0_ready[i]), 32'd0);
               check_val($sformatf("B_tail_m1rdy_c%0d[%0d]", c, i), 32'(m1_ready[i]), 32'(c == 9));
               check_val($sformatf("B_tail_m1rd_c%0d[%0d]", c, i), m1_rd[i],
                         (c == 9) ? 32'hCAFE_0009 : 32'h0);
               check_val($sformatf("B_tail_stall_c%0d[%0d]", c, i), 32'(m0_stall[i]), 32'd0);
            end
         end
      end
      next_cycle();
      m1_req = 1'b0;

      // Latency 3 (instance 2): m1 write then read back
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wd = 32'h1234_5678;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         if (c > 0) next_cycle();
         if (c == 4) begin m1_we = 1'b0; m1_wd = 32'h0; end
         @(negedge clk);
         check_val($sformatf("C_req_c%0d", c), 32'(mem_req[2]), 32'(c == 0 || c == 4));
         check_val($sformatf("C_we_c%0d", c), 32'(mem_we[2]), 32'(c == 0));
         check_val($sformatf("C_addr_c%0d", c), mem_addr[2],
                   (c == 0 || c == 4) ? 32'h20 : 32'h0);
         check_val($sformatf("C_wd_c%0d", c), mem_wd[2], (c == 0) ? 32'h1234_5678 : 32'h0);
         check_val($sformatf("C_m1rdy_c%0d", c), 32'(m1_ready[2]), 32'(c == 3 || c == 7));
         check_val($sformatf("C_m1rd_c%0d", c), m1_rd[2],
                   (c == 3 || c == 7) ? 32'h1234_5678 : 32'h0);
         check_val($sformatf("C_m0rdy_c%0d", c), 32'(m0_ready[2]), 32'd0);
         check_val($sformatf("C_stall_c%0d", c), 32'(m0_stall[2]), 32'd0);
      end
      next_cycle();
      m1_req = 1'b0;

      // Latency 3: reset lands in WAIT, then RR restarts with m0
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m1_addr = 32'h24;
      do_reset();
      @(negedge clk);
      check_val("D_issue_req", 32'(mem_req[2]), 32'd1);
      check_val("D_issue_addr", mem_addr[2], 32'h10);
      next_cycle();
      rst = 1'b1;
      m1_req = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) next_cycle();
         @(negedge clk);
         check_val($sformatf("D_rst_req_c%0d", c), 32'(mem_req[2]), 32'd0);
         check_val($sformatf("D_rst_addr_c%0d", c), mem_addr[2], 32'd0);
         check_val($sformatf("D_rst_rdy_c%0d", c), 32'({m0_ready[2], m1_ready[2]}), 32'd0);
         check_val($sformatf("D_rst_stall_c%0d", c), 32'(m0_stall[2]), 32'd1);
      end
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) next_cycle();
         @(negedge clk);
         check_val($sformatf("D_req_c%0d", c), 32'(mem_req[2]), 32'(c == 0 || c == 4));
         check_val($sformatf("D_addr_c%0d", c), mem_addr[2],
                   (c == 0) ? 32'h10 : ((c == 4) ? 32'h24 : 32'h0));
         check_val($sformatf("D_m0rdy_c%0d", c), 32'(m0_ready[2]), 32'(c == 3));
         check_val($sformatf("D_m0rd_c%0d", c), m0_rd[2], (c == 3) ? 32'hDEAD_BEEF : 32'h0);
         check_val($sformatf("D_m1rdy_c%0d", c), 32'(m1_ready[2]), 32'd0);
      end
      next_cycle();
      m0_req = 1'b0; m1_req = 1'b0;

      // Idle bus
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c > 0) next_cycle();
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            check_val($sformatf("E_bus_c%0d[%0d]", c, i),
                      32'({mem_req[i], mem_we[i], m0_ready[i], m1_ready[i], m0_stall[i]}), 32'd0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
